// File: rtl/iq_capture_mc.sv
// rtl/iq_capture_mc.sv - multi-channel IQ capture buffer with one-shot, continuous and triggered modes
module iq_capture_mc #(
    parameter int DW  = 16,
    parameter int AW  = 13,
    parameter int NCH = 1,
    parameter int CHW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic [1:0]          mode,
    input  logic                wr,
    input  logic [NCH*DW-1:0]   wr_i,
    input  logic [NCH*DW-1:0]   wr_q,
    input  logic                trig,
    input  logic [AW-1:0]       post_count,
    input  logic                rd_sync,
    input  logic [AW-1:0]       rd_offset,
    input  logic [CHW-1:0]      rd_ch,
    input  logic                rd_i,
    input  logic                rd_q,
    output logic [DW-1:0]       rd_iq,
    output logic [AW-1:0]       wr_addr_o,
    output logic [AW-1:0]       trig_addr,
    output logic                busy,
    output logic                done,
    output logic                dropped
);

    localparam int DEPTH = 1 << AW;
    localparam int WW    = 2 * NCH * DW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_POST,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_trig_mode;
    logic [AW-1:0]   r_wr_addr;
    logic [AW-1:0]   r_rd_addr;
    logic [AW-1:0]   r_trig_addr;
    logic [AW-1:0]   r_post_cnt;
    logic            r_dropped;
    logic [WW-1:0]   r_mem [DEPTH];
    logic [WW-1:0]   r_word;
    logic            w_we;
    logic            w_trig_hit;
    logic            w_drop;
    logic [AW-1:0]   w_rd_next;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and write/trigger/drop decisions; arm pre-empts any sample that cycle
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_trig_hit  = 1'b0;
        w_drop      = 1'b0;
        if (arm) begin
            w_state_nxt = (mode == 2'd0) ? S_FILL : S_RUN;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    w_drop = wr;
                end
                S_FILL: begin
                    if (wr) begin
                        w_we = 1'b1;
                        if (r_wr_addr == AW'(DEPTH - 1)) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (wr) begin
                        w_we = 1'b1;
                        if (r_trig_mode && trig) begin
                            w_trig_hit  = 1'b1;
                            w_state_nxt = (post_count == '0) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (wr) begin
                        w_we = 1'b1;
                        if (r_post_cnt <= AW'(1)) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Write pointer, trigger capture, post-trigger countdown and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr   <= '0;
            r_trig_addr <= '0;
            r_post_cnt  <= '0;
            r_dropped   <= 1'b0;
            r_trig_mode <= 1'b0;
        end else if (arm) begin
            r_wr_addr   <= '0;
            r_dropped   <= 1'b0;
            r_trig_mode <= (mode == 2'd2);
        end else begin
            if (w_we) begin
                r_wr_addr <= r_wr_addr + AW'(1);
            end
            if (w_trig_hit) begin
                r_trig_addr <= r_wr_addr;
                r_post_cnt  <= post_count;
            end else if (w_we && (r_state == S_POST)) begin
                r_post_cnt <= r_post_cnt - AW'(1);
            end
            if (w_drop) begin
                r_dropped <= 1'b1;
            end
        end
    end

    // Read pointer; the RAM is addressed with the same next value so its output tracks r_rd_addr
    assign w_rd_next = rd_sync ? (r_wr_addr + rd_offset) : (r_rd_addr + {{(AW-1){1'b0}}, rd_q});

    // Read address register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr <= '0;
        end else begin
            r_rd_addr <= w_rd_next;
        end
    end

    // Sample store: Q words above I words, all channels in one row
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_addr] <= {wr_q, wr_i};
        end
    end

    // Registered read port; a same-address write this cycle yields the old word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
        end else begin
            r_word <= r_mem[w_rd_next];
        end
    end

    // Channel and I/Q half select; out-of-range channels read as zero
    always_comb begin
        rd_iq = '0;
        for (int c = 0; c < NCH; c++) begin
            if (rd_ch == CHW'(c)) begin
                rd_iq = rd_i ? r_word[c*DW +: DW] : r_word[(NCH+c)*DW +: DW];
            end
        end
    end

    assign busy      = (r_state == S_FILL) || (r_state == S_RUN) || (r_state == S_POST);
    assign done      = (r_state == S_DONE);
    assign wr_addr_o = r_wr_addr;
    assign trig_addr = r_trig_addr;
    assign dropped   = r_dropped;

endmodule

// File: tb/tb_iq_capture_mc.sv
// tb/tb_iq_capture_mc.sv - directed and table-driven checks for iq_capture_mc
module tb_iq_capture_mc;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int NCH = 2;
    localparam int CHW = 2;

    logic              clk;
    logic              rst;
    logic              arm;
    logic [1:0]        mode;
    logic              wr;
    logic [NCH*DW-1:0] wr_i;
    logic [NCH*DW-1:0] wr_q;
    logic              trig;
    logic [AW-1:0]     post_count;
    logic              rd_sync;
    logic [AW-1:0]     rd_offset;
    logic [CHW-1:0]    rd_ch;
    logic              rd_i;
    logic              rd_q;
    logic [DW-1:0]     rd_iq;
    logic [AW-1:0]     wr_addr_o;
    logic [AW-1:0]     trig_addr;
    logic              busy;
    logic              done;
    logic              dropped;

    int total;
    int bad;

    typedef struct {
        logic           sync;
        logic [AW-1:0]  off;
        logic           q;
        logic [CHW-1:0] ch;
        logic           isel;
        logic [DW-1:0]  exp;
    } vec_t;

    vec_t vecs[10];

    iq_capture_mc #(.DW(DW), .AW(AW), .NCH(NCH), .CHW(CHW)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .mode       (mode),
        .wr         (wr),
        .wr_i       (wr_i),
        .wr_q       (wr_q),
        .trig       (trig),
        .post_count (post_count),
        .rd_sync    (rd_sync),
        .rd_offset  (rd_offset),
        .rd_ch      (rd_ch),
        .rd_i       (rd_i),
        .rd_q       (rd_q),
        .rd_iq      (rd_iq),
        .wr_addr_o  (wr_addr_o),
        .trig_addr  (trig_addr),
        .busy       (busy),
        .done       (done),
        .dropped    (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sample(input int n);
        wr_i = {16'(32'h200 + n), 16'(n)};
        wr_q = {16'(32'h300 + n), 16'(32'h100 + n)};
    endtask

    task automatic do_wr(input int n, input logic t);
        set_sample(n);
        wr   = 1'b1;
        trig = t;
        tick();
        wr   = 1'b0;
        trig = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] m);
        arm  = 1'b1;
        mode = m;
        tick();
        arm  = 1'b0;
    endtask

    task automatic sync_rd(input logic [AW-1:0] off);
        rd_sync   = 1'b1;
        rd_offset = off;
        tick();
        rd_sync   = 1'b0;
    endtask

    task automatic adv();
        rd_q = 1'b1;
        tick();
        rd_q = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; arm = 1'b0; mode = 2'd0; wr = 1'b0; wr_i = '0; wr_q = '0;
        trig = 1'b0; post_count = '0; rd_sync = 1'b0; rd_offset = '0;
        rd_ch = '0; rd_i = 1'b1; rd_q = 1'b0;

        vecs[0] = '{1'b1, 4'hF, 1'b0, 2'd0, 1'b1, 16'h0042};
        vecs[1] = '{1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 16'h0003};
        vecs[2] = '{1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 16'h0104};
        vecs[3] = '{1'b0, 4'h0, 1'b1, 2'd1, 1'b1, 16'h0205};
        vecs[4] = '{1'b0, 4'h0, 1'b0, 2'd1, 1'b0, 16'h0305};
        vecs[5] = '{1'b0, 4'h0, 1'b0, 2'd3, 1'b1, 16'h0000};
        vecs[6] = '{1'b0, 4'h0, 1'b0, 2'd2, 1'b0, 16'h0000};
        vecs[7] = '{1'b1, 4'h4, 1'b1, 2'd0, 1'b1, 16'h0017};
        vecs[8] = '{1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 16'h0018};
        vecs[9] = '{1'b1, 4'h0, 1'b0, 2'd1, 1'b1, 16'h0203};

        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_trig_addr", 32'(trig_addr), 32'd0);
        chk("rst_rd_iq", 32'(rd_iq), 32'd0);

        // writes while idle are dropped
        for (int n = 0; n < 3; n++) do_wr(100 + n, 1'b0);
        chk("idle_dropped", 32'(dropped), 32'd1);
        chk("idle_wr_addr", 32'(wr_addr_o), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // one-shot fill
        do_arm(2'd0);
        chk("fill_busy", 32'(busy), 32'd1);
        chk("fill_drop_clr", 32'(dropped), 32'd0);
        for (int n = 0; n < 20; n++) begin
            do_wr(n, 1'b0);
            if (n == 14) chk("fill_not_done", 32'(done), 32'd0);
            if (n == 15) begin
                chk("fill_done", 32'(done), 32'd1);
                chk("fill_idle", 32'(busy), 32'd0);
                chk("fill_no_drop", 32'(dropped), 32'd0);
                chk("fill_wrap", 32'(wr_addr_o), 32'd0);
            end
            if (n == 16) chk("fill_drop", 32'(dropped), 32'd1);
        end
        chk("fill_wr_addr_end", 32'(wr_addr_o), 32'd0);
        sync_rd(4'h0);
        for (int k = 0; k < 16; k++) begin
            rd_ch = 2'd0; rd_i = 1'b1; #1;
            chk($sformatf("fill_c0i_%0d", k), 32'(rd_iq), 32'(k));
            rd_i = 1'b0; #1;
            chk($sformatf("fill_c0q_%0d", k), 32'(rd_iq), 32'(32'h100 + k));
            rd_ch = 2'd1; rd_i = 1'b1; #1;
            chk($sformatf("fill_c1i_%0d", k), 32'(rd_iq), 32'(32'h200 + k));
            rd_i = 1'b0; #1;
            chk($sformatf("fill_c1q_%0d", k), 32'(rd_iq), 32'(32'h300 + k));
            adv();
        end

        // triggered capture with wrap, trigger at slot 9, 5 post samples
        post_count = 4'd5;
        do_arm(2'd2);
        for (int n = 0; n < 31; n++) begin
            do_wr(n, (n == 25) || (n == 27));
            if (n == 25) begin
                chk("trg_addr", 32'(trig_addr), 32'd9);
                chk("trg_busy", 32'(busy), 32'd1);
            end
            if (n == 29) chk("trg_not_done", 32'(done), 32'd0);
        end
        chk("trg_done", 32'(done), 32'd1);
        chk("trg_wr_addr", 32'(wr_addr_o), 32'd15);
        chk("trg_addr_kept", 32'(trig_addr), 32'd9);
        rd_ch = 2'd0; rd_i = 1'b1;
        sync_rd(4'h0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("trg_rd_%0d", k), 32'(rd_iq), 32'(15 + k));
            adv();
        end

        // trig without wr ignored; post_count 0 finishes on the trigger sample
        post_count = 4'd0;
        do_arm(2'd2);
        for (int n = 0; n < 3; n++) do_wr(n, 1'b0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("t0_busy", 32'(busy), 32'd1);
        chk("t0_done_early", 32'(done), 32'd0);
        chk("t0_trig_kept", 32'(trig_addr), 32'd9);
        do_wr(3, 1'b1);
        chk("t0_done", 32'(done), 32'd1);
        chk("t0_trig_addr", 32'(trig_addr), 32'd3);
        chk("t0_wr_addr", 32'(wr_addr_o), 32'd4);
        do_wr(4, 1'b0);
        chk("t0_drop", 32'(dropped), 32'd1);

        // continuous mode: trig ignored, re-arm coincident with wr
        do_arm(2'd1);
        for (int n = 0; n < 7; n++) do_wr(n, n == 2);
        chk("cont_trig_ign", 32'(trig_addr), 32'd3);
        chk("cont_wr_addr", 32'(wr_addr_o), 32'd7);
        set_sample(32'hABC);
        arm = 1'b1; mode = 2'd1; wr = 1'b1;
        tick();
        arm = 1'b0; wr = 1'b0;
        chk("rearm_wr_addr", 32'(wr_addr_o), 32'd0);
        chk("rearm_busy", 32'(busy), 32'd1);
        chk("rearm_drop", 32'(dropped), 32'd0);
        for (int n = 0; n < 3; n++) do_wr(32'h40 + n, 1'b0);
        chk("rearm_wr_addr3", 32'(wr_addr_o), 32'd3);

        // read port vectors
        for (int v = 0; v < 10; v++) begin
            rd_sync   = vecs[v].sync;
            rd_offset = vecs[v].off;
            rd_q      = vecs[v].q;
            rd_ch     = vecs[v].ch;
            rd_i      = vecs[v].isel;
            tick();
            chk($sformatf("vec_%0d", v), 32'(rd_iq), 32'(vecs[v].exp));
        end
        rd_sync = 1'b0;
        rd_q    = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
